// File: rtl/bus_arbiter8.sv
// bus_arbiter8: 8-way round-robin arbiter for a shared 16-bit bus.
// A holder keeps the bus for at most BURST consecutive cycles, then the
// grant rotates onward from the next index.
// Optional feature: define ARB_LOCK_EN to add a lock input. While lock is
// high, the holder may keep the bus past the BURST limit.
module bus_arbiter8 #(
  parameter int unsigned BURST = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   req,
  input  logic [127:0] din,
`ifdef ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic [7:0]   grant,
  output logic [2:0]   sel,
  output logic [15:0]  out,
  output logic         busy
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned CNTW = 4;
  localparam int unsigned DW   = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [IDXW-1:0]   sel_q;
  logic [IDXW-1:0]   ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic              busy_q;

  logic              lock_act;
  logic [IDXW-1:0]   scan_base;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_vld;
  logic              at_limit;
  logic              hold;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // The scan starts at ptr when idle. During a tenure it starts at sel+1,
  // so the current holder is considered last.
  assign scan_base = (state_q == ST_GRANT) ? IDXW'(sel_q + IDXW'(1)) : ptr_q;

  // Find the first requester at or after scan_base, wrapping modulo 8.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = scan_base;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && req[IDXW'(scan_base + IDXW'(i))]) begin
        pick_vld = 1'b1;
        pick_idx = IDXW'(scan_base + IDXW'(i));
      end
    end
  end

  assign at_limit = (cnt_q == CNTW'(BURST));
  assign hold     = req[sel_q] && (!at_limit || lock_act);

  // Pass the holder's data slice through combinationally; drive zero when idle.
  assign out = busy_q ? din[{sel_q, 4'b0000} +: DW] : '0;

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

  // Arbitration FSM with registered grant/sel/busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_GRANT;
            grant_q <= NREQ'(1) << pick_idx;
            sel_q   <= pick_idx;
            cnt_q   <= CNTW'(1);
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (hold) begin
            // Under lock, the counter saturates at BURST instead of wrapping.
            if (!at_limit) begin
              cnt_q <= CNTW'(cnt_q + CNTW'(1));
            end
          end else begin
            ptr_q <= IDXW'(sel_q + IDXW'(1));
            if (pick_vld) begin
              // Hand the bus straight to the next requester, with no idle cycle between tenures.
              grant_q <= NREQ'(1) << pick_idx;
              sel_q   <= pick_idx;
              cnt_q   <= CNTW'(1);
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: directed, self-checking bench for bus_arbiter8 (BURST=4).
// The lock scenario is compiled in only when ARB_LOCK_EN is defined.
module tb_bus_arbiter8;

  logic         clock;
  logic         reset;
  logic [7:0]   req;
  logic [127:0] din;
`ifdef ARB_LOCK_EN
  logic         lock;
`endif
  logic [7:0]   grant;
  logic [2:0]   sel;
  logic [15:0]  out;
  logic         busy;

  int tests;
  int fails;

  bus_arbiter8 #(.BURST(4)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .din   (din),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .grant (grant),
    .sel   (sel),
    .out   (out),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] exp_sel);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h0);
    chk({tag, "_out"},   32'(out),   32'h0);
    chk({tag, "_sel"},   32'(sel),   32'(exp_sel));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = '0;
    din   = '0;
`ifdef ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // Reset values.
    tick();
    chk_idle("reset", 3'd0);
    chk("reset_ptr", 32'(dut.ptr_q), 32'h0);
    chk("reset_cnt", 32'(dut.cnt_q), 32'h0);

    // Single requester 2. The grant appears one cycle later and out follows din combinationally.
    reset = 1'b0;
    din[16*2 +: 16] = 16'hBEEF;
    req = 8'b0000_0100;
    tick();
    chk("single_grant", 32'(grant), 32'h04);
    chk("single_sel",   32'(sel),   32'd2);
    chk("single_busy",  32'(busy),  32'd1);
    chk("single_out",   32'(out),   32'hBEEF);
    din[16*2 +: 16] = 16'h1234;
    #1;
    chk("comb_out",     32'(out),   32'h1234);

    // Requester 2 drops and nobody else is asking, so the arbiter goes idle and sel holds its last value.
    req = 8'h00;
    tick();
    chk_idle("release_idle", 3'd2);
    chk("release_ptr", 32'(dut.ptr_q), 32'd3);
    tick();
    chk_idle("idle_hold", 3'd2);

    // All requesters active: 4-cycle tenures rotate 0..7 and back to 0, with no gaps.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) din[16*i +: 16] = 16'(16'hA000 + i);
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rr_grant", 32'(grant), 32'(1) << (g % 8));
        chk("rr_out",   32'(out),   32'(16'hA000 + (g % 8)));
      end
    end

    // Holder 3 is not preempted by a new request on 0. When it drops after two cycles, the grant goes to 5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h08;
    tick();
    chk("np_grant1", 32'(grant), 32'h08);
    req = 8'h09;
    tick();
    chk("np_grant2", 32'(grant), 32'h08);
    chk("np_cnt2",   32'(dut.cnt_q), 32'd2);
    req = 8'h21;
    tick();
    chk("drop_grant", 32'(grant), 32'h20);
    chk("drop_sel",   32'(sel),   32'd5);
    chk("drop_ptr",   32'(dut.ptr_q), 32'd4);

    // Requester 6 is the only requester for 10 cycles. It is re-granted, and its count restarts at 1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h40;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("sole_grant", 32'(grant), 32'h40);
      chk("sole_cnt",   32'(dut.cnt_q), 32'((c % 4) + 1));
    end

    // Reset arriving mid-tenure wins. After it, the scan restarts from index 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h02;
    tick();
    chk("mid_grant", 32'(grant), 32'h02);
    tick();
    reset = 1'b1;
    tick();
    chk_idle("mid_reset", 3'd0);
    reset = 1'b0;
    req = 8'h03;
    tick();
    chk("post_reset_grant", 32'(grant), 32'h01);

`ifdef ARB_LOCK_EN
    // With lock high, holder 0 keeps the bus past BURST. Dropping lock releases the bus to 1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req  = 8'h03;
    lock = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("lock_grant", 32'(grant), 32'h01);
    end
    chk("lock_cnt_sat", 32'(dut.cnt_q), 32'd4);
    lock = 1'b0;
    tick();
    chk("unlock_grant", 32'(grant), 32'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
